// File: rtl/tdm_pkg.sv
// -----------------------------------------------------------------------------
// tdm_pkg
// Shared types and helpers for the TDM demultiplexer (tdm_demux).
//   state_t    : framing state, HUNT (searching for frame sync) or RUN (locked)
//   NCH_MAX    : largest supported channel count
//   SLOT_W_MAX : slot index width that covers NCH_MAX channels
//   slot_next  : advance a slot index, wrapping to 0 after the last slot
// -----------------------------------------------------------------------------
package tdm_pkg;

    localparam int NCH_MAX    = 16;
    localparam int SLOT_W_MAX = $clog2(NCH_MAX);

    typedef enum logic [0:0] {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Next slot index for a frame of nch slots. Any index at or beyond the
    // last slot wraps to 0, so a corrupted counter recovers on its own.
    function automatic logic [SLOT_W_MAX-1:0] slot_next(
        input logic [SLOT_W_MAX-1:0] s,
        input logic [SLOT_W_MAX:0]   nch
    );
        logic [SLOT_W_MAX:0] s_inc;
        s_inc = {1'b0, s} + {{SLOT_W_MAX{1'b0}}, 1'b1};
        if (s_inc >= nch) begin
            return {SLOT_W_MAX{1'b0}};
        end else begin
            return s_inc[SLOT_W_MAX-1:0];
        end
    endfunction

endpackage

// File: rtl/tdm_demux_if.sv
// -----------------------------------------------------------------------------
// tdm_demux_if
// Bundle of the muxed input stream and the demultiplexed channel outputs.
//   din        : W-bit muxed beat
//   din_valid  : din carries a beat this cycle
//   fsync      : beat is slot 0 (only meaningful with din_valid)
//   dout       : channel registers, channel k at dout[k*W +: W]
//   dout_valid : per-channel update strobe
//   frame_done : pulse when the last slot of a frame is captured
//   locked     : frame alignment established
//   sync_err   : pulse on a framing violation
// Modports: master = upstream source / observer, slave = the demultiplexer.
// -----------------------------------------------------------------------------
interface tdm_demux_if #(
    parameter int NCH = 2,
    parameter int W   = 1
);
    logic [W-1:0]     din;
    logic             din_valid;
    logic             fsync;
    logic [NCH*W-1:0] dout;
    logic [NCH-1:0]   dout_valid;
    logic             frame_done;
    logic             locked;
    logic             sync_err;

    modport master (
        output din, din_valid, fsync,
        input  dout, dout_valid, frame_done, locked, sync_err
    );

    modport slave (
        input  din, din_valid, fsync,
        output dout, dout_valid, frame_done, locked, sync_err
    );
endinterface

// File: rtl/tdm_slot_ctr.sv
// -----------------------------------------------------------------------------
// tdm_slot_ctr
// Framing engine of the TDM demultiplexer: slot counter, HUNT/RUN state and
// frame-sync checks.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   din_valid   : a beat is presented this cycle
//   fsync       : the presented beat claims to be slot 0
//   slot        : channel index the current beat is steered to (combinational)
//   capture_en  : current beat is to be captured (combinational)
//   locked      : registered, high while in RUN
//   sync_err    : registered one-cycle pulse on a framing violation
//   frame_done  : registered one-cycle pulse when the last slot is captured
// -----------------------------------------------------------------------------
module tdm_slot_ctr
    import tdm_pkg::*;
#(
    parameter int NCH = 2,
    parameter int CW  = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          din_valid,
    input  logic          fsync,
    output logic [CW-1:0] slot,
    output logic          capture_en,
    output logic          locked,
    output logic          sync_err,
    output logic          frame_done
);

    localparam logic [SLOT_W_MAX:0] NCH_V     = (SLOT_W_MAX + 1)'(NCH);
    localparam logic [CW-1:0]       LAST_SLOT = CW'(NCH - 1);
    localparam logic [CW-1:0]       SLOT_ZERO = {CW{1'b0}};

    state_t        state_r,      state_nxt_s;
    logic [CW-1:0] slot_r,       slot_nxt_s;
    logic [CW-1:0] cap_slot_s;
    logic          capture_en_s;
    logic          sync_err_nxt_s;
    logic          frame_done_nxt_s;
    logic          locked_r;
    logic          sync_err_r;
    logic          frame_done_r;

    // Register state, slot counter and the framing status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= HUNT;
            slot_r       <= SLOT_ZERO;
            locked_r     <= 1'b0;
            sync_err_r   <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            slot_r       <= slot_nxt_s;
            locked_r     <= (state_nxt_s == RUN);
            sync_err_r   <= sync_err_nxt_s;
            frame_done_r <= frame_done_nxt_s;
        end
    end

    // Next-state, steering and framing checks; idle cycles change nothing
    always_comb begin
        state_nxt_s      = state_r;
        slot_nxt_s       = slot_r;
        cap_slot_s       = SLOT_ZERO;
        capture_en_s     = 1'b0;
        sync_err_nxt_s   = 1'b0;
        frame_done_nxt_s = 1'b0;
        if (din_valid) begin
            case (state_r)
                HUNT: begin
                    if (fsync) begin
                        capture_en_s = 1'b1;
                        cap_slot_s   = SLOT_ZERO;
                        slot_nxt_s   = CW'(slot_next({SLOT_W_MAX{1'b0}}, NCH_V));
                        state_nxt_s  = RUN;
                    end else begin
                        // Unaligned beats are discarded while hunting
                        slot_nxt_s = SLOT_ZERO;
                    end
                end
                RUN: begin
                    if (fsync && (slot_r != SLOT_ZERO)) begin
                        // Early sync: realign, treating this beat as slot 0
                        sync_err_nxt_s = 1'b1;
                        capture_en_s   = 1'b1;
                        cap_slot_s     = SLOT_ZERO;
                        slot_nxt_s     = CW'(slot_next({SLOT_W_MAX{1'b0}}, NCH_V));
                    end else if (!fsync && (slot_r == SLOT_ZERO)) begin
                        // Missing sync: alignment lost, drop beat and re-hunt
                        sync_err_nxt_s = 1'b1;
                        slot_nxt_s     = SLOT_ZERO;
                        state_nxt_s    = HUNT;
                    end else begin
                        capture_en_s     = 1'b1;
                        cap_slot_s       = slot_r;
                        slot_nxt_s       = CW'(slot_next(SLOT_W_MAX'(slot_r), NCH_V));
                        frame_done_nxt_s = (slot_r == LAST_SLOT);
                    end
                end
                default: begin
                    state_nxt_s = HUNT;
                    slot_nxt_s  = SLOT_ZERO;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    assign slot       = cap_slot_s;
    assign capture_en = capture_en_s;
    assign locked     = locked_r;
    assign sync_err   = sync_err_r;
    assign frame_done = frame_done_r;

endmodule

// File: rtl/tdm_demux.sv
// -----------------------------------------------------------------------------
// tdm_demux
// 1-to-NCH time-division demultiplexer. Serial W-bit beats, with a frame
// sync on slot 0, are steered into per-channel registers.
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : tdm_demux_if.slave (din/din_valid/fsync in; dout,
//                dout_valid, frame_done, locked, sync_err out, all registered)
// Build option:
//   TDM_DEMUX_FRAME_LATCH_EN : beats are collected in shadow registers and
//   dout is updated all at once when a frame completes, so a frame aborted
//   by a framing error never reaches dout. Undefined: each channel updates
//   as soon as its beat arrives and no shadows exist.
// -----------------------------------------------------------------------------
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int NCH = 2,
    parameter int W   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    tdm_demux_if.slave bus
);

    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [CW-1:0]    slot_s;
    logic             capture_en_s;
    logic             locked_s;
    logic             sync_err_s;
    logic             frame_done_s;
    logic [NCH*W-1:0] dout_r,  dout_nxt_s;
    logic [NCH-1:0]   dv_r,    dv_nxt_s;

    tdm_slot_ctr #(
        .NCH (NCH),
        .CW  (CW)
    ) u_slot_ctr (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_valid  (bus.din_valid),
        .fsync      (bus.fsync),
        .slot       (slot_s),
        .capture_en (capture_en_s),
        .locked     (locked_s),
        .sync_err   (sync_err_s),
        .frame_done (frame_done_s)
    );

`ifdef TDM_DEMUX_FRAME_LATCH_EN
    logic [NCH*W-1:0] shadow_r, shadow_nxt_s;
    logic             frame_end_s;

    // Collect beats in the shadows; publish the whole frame on its last beat
    always_comb begin
        shadow_nxt_s = shadow_r;
        for (int k = 0; k < NCH; k++) begin
            if (capture_en_s && (slot_s == CW'(k))) begin
                shadow_nxt_s[k*W +: W] = bus.din;
            end else begin
                shadow_nxt_s[k*W +: W] = shadow_r[k*W +: W];
            end
        end
        // A realign always steers to slot 0, so it can never end a frame
        frame_end_s = capture_en_s && (slot_s == CW'(NCH - 1));
        if (frame_end_s) begin
            dout_nxt_s = shadow_nxt_s;
            dv_nxt_s   = {NCH{1'b1}};
        end else begin
            dout_nxt_s = dout_r;
            dv_nxt_s   = {NCH{1'b0}};
        end
    end

    // Shadow register bank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_r <= {(NCH*W){1'b0}};
        end else begin
            shadow_r <= shadow_nxt_s;
        end
    end
`else
    // Steer the accepted beat straight into its channel and flag that channel
    always_comb begin
        dout_nxt_s = dout_r;
        dv_nxt_s   = {NCH{1'b0}};
        for (int k = 0; k < NCH; k++) begin
            if (capture_en_s && (slot_s == CW'(k))) begin
                dout_nxt_s[k*W +: W] = bus.din;
                dv_nxt_s[k]          = 1'b1;
            end else begin
                dv_nxt_s[k] = 1'b0;
            end
        end
    end
`endif

    // Channel output registers and their update strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_r <= {(NCH*W){1'b0}};
            dv_r   <= {NCH{1'b0}};
        end else begin
            dout_r <= dout_nxt_s;
            dv_r   <= dv_nxt_s;
        end
    end

    assign bus.dout       = dout_r;
    assign bus.dout_valid = dv_r;
    assign bus.frame_done = frame_done_s;
    assign bus.locked     = locked_s;
    assign bus.sync_err   = sync_err_s;

endmodule

// File: tb/tb_tdm_demux.sv
// -----------------------------------------------------------------------------
// tb_tdm_demux
// Directed bench for tdm_demux. Instance A: NCH=2, W=1. Instance B: NCH=4,
// W=8. Expected values are hand-computed; the latch-mode sequence is used
// when TDM_DEMUX_FRAME_LATCH_EN is defined.
// -----------------------------------------------------------------------------
module tb_tdm_demux;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    tdm_demux_if #(.NCH(2), .W(1)) if_a ();
    tdm_demux_if #(.NCH(4), .W(8)) if_b ();

    tdm_demux #(.NCH(2), .W(1)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    tdm_demux #(.NCH(4), .W(8)) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        assert (obs === exp) else begin
            n_err = n_err + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [1:0] d, input logic [1:0] v,
                         input logic fd, input logic lk, input logic se);
        chk({tag, ".dout"},       32'(if_a.dout),       32'(d));
        chk({tag, ".dout_valid"}, 32'(if_a.dout_valid), 32'(v));
        chk({tag, ".frame_done"}, 32'(if_a.frame_done), 32'(fd));
        chk({tag, ".locked"},     32'(if_a.locked),     32'(lk));
        chk({tag, ".sync_err"},   32'(if_a.sync_err),   32'(se));
    endtask

    task automatic chk_b(input string tag, input logic [31:0] d, input logic [3:0] v,
                         input logic fd, input logic lk, input logic se);
        chk({tag, ".dout"},       if_b.dout,            d);
        chk({tag, ".dout_valid"}, 32'(if_b.dout_valid), 32'(v));
        chk({tag, ".frame_done"}, 32'(if_b.frame_done), 32'(fd));
        chk({tag, ".locked"},     32'(if_b.locked),     32'(lk));
        chk({tag, ".sync_err"},   32'(if_b.sync_err),   32'(se));
    endtask

    // Present one cycle on A (B idle), then sample 1 time unit after the edge
    task automatic drive_a(input logic v, input logic fs, input logic d);
        if_a.din_valid = v;
        if_a.fsync     = fs;
        if_a.din       = d;
        if_b.din_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Present one cycle on B (A idle), then sample 1 time unit after the edge
    task automatic drive_b(input logic v, input logic fs, input logic [7:0] d);
        if_b.din_valid = v;
        if_b.fsync     = fs;
        if_b.din       = d;
        if_a.din_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp          = 0;
        n_err          = 0;
        rst_n          = 1'b0;
        if_a.din       = 1'b0;
        if_a.din_valid = 1'b0;
        if_a.fsync     = 1'b0;
        if_b.din       = 8'h00;
        if_b.din_valid = 1'b0;
        if_b.fsync     = 1'b0;
        #13;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_a("rst_a", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        chk_b("rst_b", 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0);

`ifdef TDM_DEMUX_FRAME_LATCH_EN
        // Lock and steer, frame-latched
        drive_a(1'b1, 1'b1, 1'b1); chk_a("fl_b1", 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        drive_a(1'b1, 1'b0, 1'b0); chk_a("fl_b2", 2'b01, 2'b11, 1'b1, 1'b1, 1'b0);
        drive_a(1'b1, 1'b1, 1'b0); chk_a("fl_b3", 2'b01, 2'b00, 1'b0, 1'b1, 1'b0);
        drive_a(1'b1, 1'b0, 1'b1); chk_a("fl_b4", 2'b10, 2'b11, 1'b1, 1'b1, 1'b0);
        // Aborted frame never reaches dout; realigned frame does
        drive_b(1'b1, 1'b1, 8'h11); chk_b("fl_e1", 32'h0, 4'b0000, 1'b0, 1'b1, 1'b0);
        drive_b(1'b1, 1'b0, 8'h22); chk_b("fl_e2", 32'h0, 4'b0000, 1'b0, 1'b1, 1'b0);
        drive_b(1'b1, 1'b1, 8'hA5); chk_b("fl_e3", 32'h0, 4'b0000, 1'b0, 1'b1, 1'b1);
        drive_b(1'b1, 1'b0, 8'h33); chk_b("fl_e4", 32'h0, 4'b0000, 1'b0, 1'b1, 1'b0);
        drive_b(1'b1, 1'b0, 8'h44); chk_b("fl_e5", 32'h0, 4'b0000, 1'b0, 1'b1, 1'b0);
        drive_b(1'b1, 1'b0, 8'h55); chk_b("fl_e6", 32'h554433A5, 4'b1111, 1'b1, 1'b1, 1'b0);
`else
        // Lock and steer
        drive_a(1'b1, 1'b1, 1'b1); chk_a("ls_b1", 2'b01, 2'b01, 1'b0, 1'b1, 1'b0);
        drive_a(1'b1, 1'b0, 1'b0); chk_a("ls_b2", 2'b01, 2'b10, 1'b1, 1'b1, 1'b0);
        drive_a(1'b1, 1'b1, 1'b0); chk_a("ls_b3", 2'b00, 2'b01, 1'b0, 1'b1, 1'b0);
        drive_a(1'b1, 1'b0, 1'b1); chk_a("ls_b4", 2'b10, 2'b10, 1'b1, 1'b1, 1'b0);
        // fsync without din_valid is ignored
        drive_a(1'b0, 1'b1, 1'b1); chk_a("idle",  2'b10, 2'b00, 1'b0, 1'b1, 1'b0);
        // Missing sync at slot 0
        drive_a(1'b1, 1'b0, 1'b1); chk_a("miss",  2'b10, 2'b00, 1'b0, 1'b0, 1'b1);
        // Relock, idle gap, resume at slot 1
        drive_a(1'b1, 1'b1, 1'b1); chk_a("relock", 2'b11, 2'b01, 1'b0, 1'b1, 1'b0);
        repeat (5) drive_a(1'b0, 1'b0, 1'b0);
        chk_a("gap",    2'b11, 2'b00, 1'b0, 1'b1, 1'b0);
        drive_a(1'b1, 1'b0, 1'b0); chk_a("resume", 2'b01, 2'b10, 1'b1, 1'b1, 1'b0);
        drive_a(1'b1, 1'b1, 1'b1); chk_a("midfrm", 2'b01, 2'b01, 1'b0, 1'b1, 1'b0);
        // Early sync on NCH=4, W=8
        drive_b(1'b1, 1'b1, 8'h11); chk_b("es_1", 32'h00000011, 4'b0001, 1'b0, 1'b1, 1'b0);
        drive_b(1'b1, 1'b0, 8'h22); chk_b("es_2", 32'h00002211, 4'b0010, 1'b0, 1'b1, 1'b0);
        drive_b(1'b1, 1'b1, 8'hA5); chk_b("es_3", 32'h000022A5, 4'b0001, 1'b0, 1'b1, 1'b1);
        drive_b(1'b1, 1'b0, 8'h33); chk_b("es_4", 32'h000033A5, 4'b0010, 1'b0, 1'b1, 1'b0);
        drive_b(1'b1, 1'b0, 8'h44); chk_b("es_5", 32'h004433A5, 4'b0100, 1'b0, 1'b1, 1'b0);
        drive_b(1'b1, 1'b0, 8'h55); chk_b("es_6", 32'h554433A5, 4'b1000, 1'b1, 1'b1, 1'b0);
        drive_b(1'b1, 1'b0, 8'h66); chk_b("es_7", 32'h554433A5, 4'b0000, 1'b0, 1'b0, 1'b1);
        // Relock B and leave it mid-frame for the reset check
        drive_b(1'b1, 1'b1, 8'h77); chk_b("es_8", 32'h55443377, 4'b0001, 1'b0, 1'b1, 1'b0);
        // Asynchronous reset away from any clock edge
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst.a_dout",   32'(if_a.dout),   32'h0);
        chk("arst.a_locked", 32'(if_a.locked), 32'h0);
        chk("arst.b_dout",   if_b.dout,        32'h0);
        chk("arst.b_locked", 32'(if_b.locked), 32'h0);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // Hunt drop: unsynced beats discarded until fsync
        drive_a(1'b1, 1'b0, 1'b1); chk_a("hunt1", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        drive_a(1'b1, 1'b0, 1'b1); chk_a("hunt2", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        drive_a(1'b1, 1'b0, 1'b1); chk_a("hunt3", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        drive_a(1'b1, 1'b1, 1'b1); chk_a("hunt4", 2'b01, 2'b01, 1'b0, 1'b1, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Receive end of the team's time-division mux path: a 1-to-NCH demultiplexer.
- Accepts a serial stream of W-bit beats with a frame-sync marker on slot 0.
- Steers each beat to its channel register and raises a per-channel valid strobe.
- Sits downstream of the mux21 / N:1 mux chain and restores the parallel channels.

Parameters:
- NCH, 2, number of channels (slots per frame), 2..16.
- W, 1, width of one beat / one channel in bits, 1..32.
- CW, $clog2(NCH), slot counter width (derived, not overridable).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- din  input  W  muxed data beat.
- din_valid  input  1  din is a beat this cycle.
- fsync  input  1  qualifies din as slot 0; ignored when din_valid=0.
- dout  output  NCH*W  channel registers; channel k is dout[k*W +: W].
- dout_valid  output  NCH  one-cycle strobe per channel when its register updates.
- frame_done  output  1  one-cycle pulse when slot NCH-1 is captured.
- locked  output  1  high while in RUN.
- sync_err  output  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset (async assert, sync release): dout=0, dout_valid=0, frame_done=0, sync_err=0, locked=0, state=HUNT, slot=0.
- Latency: a beat accepted at edge N appears on dout and dout_valid at edge N (registered); visible the cycle after it is presented.
- Cycles with din_valid=0: no state change; all strobes are low.
- State HUNT:
  - Beats without fsync are dropped.
  - A beat with fsync is captured to ch0; slot becomes 1 (or 0 if NCH=1 is not allowed); state goes to RUN; locked=1.
- State RUN, slot s:
  - A valid beat is captured to ch s; dout_valid[s] pulses; slot goes to s+1.
  - At s=NCH-1: frame_done pulses and slot wraps to 0.
  - fsync with s!=0: sync_err pulses and the beat realigns as ch0 capture; slot becomes 1; frame_done is not asserted.
  - No fsync with s=0: sync_err pulses, the beat is dropped, state goes to HUNT, locked=0. dout holds its last values.
- Priority: reset > realign on fsync > normal capture.
- Unaddressed channels hold their values. At most one dout_valid bit is high per cycle.
- Reset mid-frame discards the partial frame; dout returns to 0.

Optional Feature:
- Macro TDM_DEMUX_FRAME_LATCH_EN.
- Defined:
  - Beats go to internal shadow registers.
  - dout updates atomically from the shadows on the frame_done cycle; all dout_valid bits pulse together then.
  - A frame aborted by sync_err never reaches dout.
- Undefined: per-slot immediate update as above. No shadow registers are built.

Decomposition:
- Package tdm_pkg holds:
  - state enum {HUNT, RUN};
  - NCH_MAX = 16;
  - the helper function slot_next(s, nch) that handles the wrap.
- Sub-module tdm_slot_ctr holds:
  - the slot counter;
  - the state register;
  - framing checks.
  - Outputs: slot, locked, sync_err, frame_done, capture_en.
- The top level contains the capture / shadow registers and the dout_valid decode.

Test Plan (NCH=2, W=1 unless stated):
- Lock and steer:
  - Stimulus: after reset, beats (fsync=1, din=1), (0, 0), (1, 0), (0, 1).
  - Response: dout = 2'b01, then 2'b00, then 2'b10. dout_valid sequence 01, 10, 01, 10. frame_done on beats 2 and 4. locked=1 from beat 1.
- Hunt drop:
  - Stimulus: three beats with fsync=0, then fsync=1 din=1.
  - Response: dout stays 0 and locked stays 0 until the 4th beat. Then dout[0]=1.
- Early sync:
  - Stimulus: with NCH=4, W=8, locked, fsync arrives at slot 2 with din=8'hA5.
  - Response: sync_err pulse, ch0=8'hA5, slot=1, no frame_done.
- Missing sync:
  - Stimulus: locked; beat at slot 0 with fsync=0.
  - Response: sync_err pulse, locked=0, dout unchanged, beat dropped.
- Idle gaps and reset:
  - Stimulus: din_valid low for 5 cycles mid-frame, then resume. Separately, assert rst_n=0 asynchronously mid-frame.
  - Response: slot continues correctly across the gap. On reset all outputs go to 0 immediately, independent of clk.
- FRAME_LATCH_EN:
  - Stimulus: as in the first scenario.
  - Response: dout is unchanged after beat 1 and shows 2'b01 only on the frame_done cycle, with dout_valid=11.
